// File: rtl/sbox_perm_builder.sv
// Builds a 2^W-entry S-box permutation from a stream of chaotic sample words, discarding duplicates.
// Optional inverse table and read port are enabled by defining SBOX_PERM_INVERSE_EN.
module sbox_perm_builder #(
    parameter int unsigned W     = 8,
    parameter int unsigned IN_W  = 23,
    parameter int unsigned REJ_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             done,
    output logic [W:0]       count,
    output logic [REJ_W-1:0] reject_cnt,
    input  logic [W-1:0]     rd_addr,
    output logic [W-1:0]     rd_data
`ifdef SBOX_PERM_INVERSE_EN
    ,
    input  logic [W-1:0]     inv_addr,
    output logic [W-1:0]     inv_data
`endif
);

    localparam int unsigned N = 1 << W;
    localparam logic [W:0] CntLast = (W + 1)'(N - 2);
    localparam logic [W:0] CntFull = (W + 1)'(N);
    localparam logic [W:0] CntOne  = (W + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StTail,
        StDone
    } state_e;

    state_e         state_q;
    logic [N-1:0]   seen_q;
    logic [W-1:0]   tbl_q [N];

    logic [W-1:0]   cand;
    logic [W-1:0]   free_idx;
    logic           accept;
    logic           is_new;
    logic           wr_en;
    logic [W-1:0]   wr_addr;
    logic [W-1:0]   wr_data;

    assign cand   = in_data[W-1:0] ^ in_data[2*W-1:W];
    // A start pulse wins over a word presented in the same cycle.
    assign accept = in_valid & in_ready & ~start;
    assign is_new = ~seen_q[cand];

    if (IN_W > 2 * W) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^in_data[IN_W-1:2*W];
    end

    // Lowest-index unset bit; exactly one remains when in TAIL.
    always_comb begin
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!seen_q[i]) begin
                free_idx = W'(i);
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = count[W-1:0];
        wr_data = cand;
        if (!rst && !start) begin
            if (state_q == StFill && accept && is_new) begin
                wr_en = 1'b1;
            end else if (state_q == StTail) begin
                wr_en   = 1'b1;
                wr_addr = '1;
                wr_data = free_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready   <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            reject_cnt <= '0;
            seen_q     <= '0;
        end else if (start) begin
            state_q    <= StFill;
            in_ready   <= 1'b1;
            done       <= 1'b0;
            count      <= '0;
            reject_cnt <= '0;
            seen_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                end
                StFill: begin
                    if (accept) begin
                        if (is_new) begin
                            seen_q[cand] <= 1'b1;
                            count        <= count + CntOne;
                            if (count == CntLast) begin
                                state_q  <= StTail;
                                in_ready <= 1'b0;
                            end
                        end else if (reject_cnt != '1) begin
                            reject_cnt <= reject_cnt + REJ_W'(1);
                        end
                    end
                end
                StTail: begin
                    seen_q[free_idx] <= 1'b1;
                    count            <= CntFull;
                    state_q          <= StDone;
                    in_ready         <= 1'b0;
                    done             <= 1'b1;
                end
                StDone: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Table storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= tbl_q[rd_addr];
        end
    end

`ifdef SBOX_PERM_INVERSE_EN
    logic [W-1:0] inv_q [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inv_q[wr_data] <= wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_data <= '0;
        end else begin
            inv_data <= inv_q[inv_addr];
        end
    end
`endif

endmodule

// File: tb/tb_sbox_perm_builder.sv
// Directed bench for sbox_perm_builder: a W=8 instance for the main flow and a W=4, REJ_W=4
// instance for random fill and reject saturation.
module tb_sbox_perm_builder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // W=8 instance
    logic        start8 = 1'b0;
    logic        valid8 = 1'b0;
    logic [22:0] data8  = '0;
    logic        ready8;
    logic        done8;
    logic [8:0]  count8;
    logic [15:0] rej8;
    logic [7:0]  rdaddr8 = '0;
    logic [7:0]  rddata8;

    // W=4 instance
    logic        start4 = 1'b0;
    logic        valid4 = 1'b0;
    logic [11:0] data4  = '0;
    logic        ready4;
    logic        done4;
    logic [4:0]  count4;
    logic [3:0]  rej4;
    logic [3:0]  rdaddr4 = '0;
    logic [3:0]  rddata4;

`ifdef SBOX_PERM_INVERSE_EN
    logic [7:0]  invaddr8 = '0;
    logic [7:0]  invdata8;
    logic [3:0]  invaddr4 = '0;
    logic [3:0]  invdata4;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sbox_perm_builder #(.W(8), .IN_W(23), .REJ_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .in_valid   (valid8),
        .in_data    (data8),
        .in_ready   (ready8),
        .done       (done8),
        .count      (count8),
        .reject_cnt (rej8),
        .rd_addr    (rdaddr8),
        .rd_data    (rddata8)
`ifdef SBOX_PERM_INVERSE_EN
        ,
        .inv_addr   (invaddr8),
        .inv_data   (invdata8)
`endif
    );

    sbox_perm_builder #(.W(4), .IN_W(12), .REJ_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .in_valid   (valid4),
        .in_data    (data4),
        .in_ready   (ready4),
        .done       (done4),
        .count      (count4),
        .reject_cnt (rej4),
        .rd_addr    (rdaddr4),
        .rd_data    (rddata4)
`ifdef SBOX_PERM_INVERSE_EN
        ,
        .inv_addr   (invaddr4),
        .inv_data   (invdata4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [22:0] w);
        valid8 = 1'b1;
        data8  = w;
        tick();
        valid8 = 1'b0;
    endtask

    task automatic send4(input logic [11:0] w);
        valid4 = 1'b1;
        data4  = w;
        tick();
        valid4 = 1'b0;
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if (ready8 !== 1'b0) $display("FAIL reset_ready got %0b want 0", ready8);
        else n_pass++;
        n_total++;
        if (done8 !== 1'b0) $display("FAIL reset_done got %0b want 0", done8);
        else n_pass++;
        n_total++;
        if (count8 !== 9'd0) $display("FAIL reset_count got %0d want 0", count8);
        else n_pass++;
        n_total++;
        if (rej8 !== 16'd0) $display("FAIL reset_rej got %0d want 0", rej8);
        else n_pass++;
        n_total++;
        if (rddata8 !== 8'd0) $display("FAIL reset_rddata got %0h want 0", rddata8);
        else n_pass++;
        n_total++;
        if (count4 !== 5'd0 || ready4 !== 1'b0 || done4 !== 1'b0)
            $display("FAIL reset_dut4 got count=%0d ready=%0b done=%0b want 0/0/0",
                     count4, ready4, done4);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_ignore();
        send8(23'h000505);
        n_total++;
        if (count8 !== 9'd0 || rej8 !== 16'd0 || ready8 !== 1'b0)
            $display("FAIL idle_ignore got count=%0d rej=%0d ready=%0b want 0/0/0",
                     count8, rej8, ready8);
        else n_pass++;
    endtask

    task automatic test_duplicate();
        pulse_start8();
        n_total++;
        if (ready8 !== 1'b1) $display("FAIL start_ready got %0b want 1", ready8);
        else n_pass++;
        send8(23'h000505);
        send8(23'h000A0A);
        n_total++;
        if (count8 !== 9'd1) $display("FAIL dup_count got %0d want 1", count8);
        else n_pass++;
        n_total++;
        if (rej8 !== 16'd1) $display("FAIL dup_rej got %0d want 1", rej8);
        else n_pass++;
        // Upper bits must be ignored: cand = 02 ^ 01 = 03.
        send8(23'h7F0102);
        n_total++;
        if (count8 !== 9'd2) $display("FAIL hibits_count got %0d want 2", count8);
        else n_pass++;
        rdaddr8 = 8'd0;
        tick();
        n_total++;
        if (rddata8 !== 8'h00) $display("FAIL dup_tbl0 got %0h want 00", rddata8);
        else n_pass++;
        rdaddr8 = 8'd1;
        tick();
        n_total++;
        if (rddata8 !== 8'h03) $display("FAIL hibits_tbl1 got %0h want 03", rddata8);
        else n_pass++;
    endtask

    task automatic test_abort();
        pulse_start8();
        for (int i = 0; i < 100; i++) begin
            send8(23'(i));
        end
        n_total++;
        if (count8 !== 9'd100) $display("FAIL abort_pre_count got %0d want 100", count8);
        else n_pass++;
        send8(23'h0000AB);
        n_total++;
        if (rej8 !== 16'd0) $display("FAIL abort_pre_rej got %0d want 0", rej8);
        else n_pass++;
        send8(23'h000010);
        n_total++;
        if (rej8 !== 16'd1) $display("FAIL abort_dup_rej got %0d want 1", rej8);
        else n_pass++;
        // start together with a valid word: start wins and the word is dropped.
        start8 = 1'b1;
        valid8 = 1'b1;
        data8  = 23'h0000C8;
        tick();
        start8 = 1'b0;
        valid8 = 1'b0;
        n_total++;
        if (count8 !== 9'd0 || rej8 !== 16'd0 || ready8 !== 1'b1 || done8 !== 1'b0)
            $display("FAIL abort_state got count=%0d rej=%0d ready=%0b done=%0b want 0/0/1/0",
                     count8, rej8, ready8, done8);
        else n_pass++;
        tick();
        n_total++;
        if (count8 !== 9'd0) $display("FAIL start_priority got %0d want 0", count8);
        else n_pass++;
    endtask

    task automatic test_full_fill();
        for (int i = 0; i < 255; i++) begin
            valid8 = 1'b1;
            data8  = 23'(i);
            tick();
        end
        valid8 = 1'b0;
        n_total++;
        if (count8 !== 9'd255 || ready8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL tail_entry got count=%0d ready=%0b done=%0b want 255/0/0",
                     count8, ready8, done8);
        else n_pass++;
        tick();
        n_total++;
        if (done8 !== 1'b1 || count8 !== 9'd256)
            $display("FAIL full_done got done=%0b count=%0d want 1/256", done8, count8);
        else n_pass++;
        n_total++;
        if (rej8 !== 16'd0) $display("FAIL full_rej got %0d want 0", rej8);
        else n_pass++;
        for (int a = 0; a < 256; a++) begin
            rdaddr8 = 8'(a);
            tick();
            n_total++;
            if (rddata8 !== 8'(a)) $display("FAIL full_tbl[%0d] got %0h want %0h", a, rddata8, a);
            else n_pass++;
        end
        // Words in DONE are ignored.
        send8(23'h000505);
        n_total++;
        if (rej8 !== 16'd0 || count8 !== 9'd256 || done8 !== 1'b1)
            $display("FAIL done_ignore got rej=%0d count=%0d done=%0b want 0/256/1",
                     rej8, count8, done8);
        else n_pass++;
    endtask

`ifdef SBOX_PERM_INVERSE_EN
    task automatic test_inverse();
        for (int a = 0; a < 256; a++) begin
            rdaddr8 = 8'(a);
            tick();
            invaddr8 = rddata8;
            tick();
            n_total++;
            if (invdata8 !== 8'(a)) $display("FAIL inv[%0d] got %0h want %0h", a, invdata8, a);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random_w4();
        bit seen_v [16];
        int cyc = 0;
        bit tail_bad = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        valid4 = 1'b1;
        while (!done4 && cyc < 2000) begin
            data4 = 12'($urandom);
            tick();
            cyc++;
            if (count4 >= 5'd15 && ready4 !== 1'b0) tail_bad = 1'b1;
        end
        valid4 = 1'b0;
        n_total++;
        if (done4 !== 1'b1) $display("FAIL rand4_done got %0b want 1 after %0d cycles", done4, cyc);
        else n_pass++;
        n_total++;
        if (count4 !== 5'd16) $display("FAIL rand4_count got %0d want 16", count4);
        else n_pass++;
        tick();
        n_total++;
        if (tail_bad || ready4 !== 1'b0)
            $display("FAIL rand4_ready got ready=%0b tail_bad=%0b want 0/0", ready4, tail_bad);
        else n_pass++;
        for (int a = 0; a < 16; a++) seen_v[a] = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rdaddr4 = 4'(a);
            tick();
            n_total++;
            if ($isunknown(rddata4) || seen_v[rddata4])
                $display("FAIL rand4_distinct[%0d] got %0h want unseen value", a, rddata4);
            else begin
                seen_v[rddata4] = 1'b1;
                n_pass++;
            end
        end
    endtask

    task automatic test_saturate_w4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        send4(12'h000);
        for (int i = 0; i < 20; i++) begin
            valid4 = 1'b1;
            data4  = 12'hA55;
            tick();
            if (i == 14) begin
                n_total++;
                if (rej4 !== 4'd15) $display("FAIL sat_reach got %0d want 15", rej4);
                else n_pass++;
            end
        end
        valid4 = 1'b0;
        n_total++;
        if (rej4 !== 4'd15) $display("FAIL sat_hold got %0d want 15", rej4);
        else n_pass++;
        n_total++;
        if (count4 !== 5'd1) $display("FAIL sat_count got %0d want 1", count4);
        else n_pass++;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_ignore();
        test_duplicate();
        test_abort();
        test_full_fill();
`ifdef SBOX_PERM_INVERSE_EN
        test_inverse();
`endif
        test_random_w4();
        test_saturate_w4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
